// File: rtl/adau1761_config_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and command word for the ADAU1761 config sequencer.
package adau_cfg_pkg;

  localparam logic [8:0] OP_STOP  = 9'h0FF;
  localparam logic [8:0] OP_DELAY = 9'h0EF;
  localparam logic [8:0] OP_NOP   = 9'h0FE;
  localparam logic [8:0] OP_END   = 9'h000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_WAIT_RSP,
    ST_DELAY,
    ST_ABORT,
    ST_BACKOFF
  } state_e;

  typedef enum logic [2:0] {
    OPC_BYTE,
    OPC_STOP,
    OPC_DELAY,
    OPC_NOP,
    OPC_END,
    OPC_ILLEGAL
  } op_e;

  typedef struct packed {
    logic       stop;
    logic [7:0] byte_val;
  } cmd_t;

  function automatic op_e decode_op(input logic [8:0] w);
    op_e op;
    if (w[8]) begin
      op = OPC_BYTE;
    end else begin
      case (w)
        OP_STOP:  op = OPC_STOP;
        OP_DELAY: op = OPC_DELAY;
        OP_NOP:   op = OPC_NOP;
        OP_END:   op = OPC_END;
        default:  op = OPC_ILLEGAL;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/adau1761_config_sequencer_delay_timer.sv
// Down-counter shared by DELAY ops and NACK back-off; expired_o pulses on the last counted cycle.
module adau_delay_timer #(
  parameter int DELAY_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expired_o
);

  localparam int LOAD_V = (DELAY_CYCLES < 1) ? 1 : DELAY_CYCLES;
  localparam int CNT_W  = (DELAY_CYCLES < 1) ? 1 : $clog2(DELAY_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(LOAD_V);
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/adau1761_config_sequencer.sv
// Config-ROM microcode sequencer feeding an I2C byte engine.
// Define ADAU_SEQ_RETRY_EN to enable NACK retry with rewind to the transaction start.
module adau1761_config_sequencer
  import adau_cfg_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int WORD_W       = 9,
  parameter int DELAY_CYCLES = 100000,
  parameter int MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_stop,
  output logic [7:0]        cmd_byte,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        retry_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, txn_q, txn_d;
  cmd_t              cmd_q, cmd_d;
  logic              done_q, done_d, error_q, error_d;
  logic              tmr_load_s, tmr_expired_s;
  op_e               raw_op_s, op_s;
  logic              retry_ok_s;

`ifdef ADAU_SEQ_RETRY_EN
  logic [7:0] tries_q, tries_d, retry_cnt_q, retry_cnt_d;
  assign retry_ok_s = (tries_q < 8'(MAX_RETRY));
`else
  logic [7:0] unused_max_retry_s;
  assign unused_max_retry_s = 8'(MAX_RETRY);
  assign retry_ok_s = 1'b0;
`endif

  adau_delay_timer #(.DELAY_CYCLES(DELAY_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load_s),
    .expired_o (tmr_expired_s)
  );

  // The last ROM word can never advance, so anything executable there ends the program.
  always_comb begin
    raw_op_s = decode_op(rom_data[8:0]);
    if ((addr_q == LAST_ADDR) && (raw_op_s != OPC_ILLEGAL)) begin
      op_s = OPC_END;
    end else begin
      op_s = raw_op_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = start ? ST_FETCH : ST_IDLE;
      ST_FETCH:    state_d = ST_DECODE;
      ST_DECODE: begin
        case (op_s)
          OPC_BYTE, OPC_STOP: state_d = ST_SEND;
          OPC_DELAY:          state_d = ST_DELAY;
          OPC_NOP:            state_d = ST_FETCH;
          default:            state_d = ST_IDLE;
        endcase
      end
      ST_SEND: begin
        if (cmd_ready) begin
          state_d = cmd_q.stop ? ST_FETCH : ST_WAIT_RSP;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          state_d = rsp_nack ? ST_ABORT : ST_FETCH;
        end else begin
          state_d = ST_WAIT_RSP;
        end
      end
      ST_DELAY:    state_d = tmr_expired_s ? ST_FETCH : ST_DELAY;
      ST_ABORT: begin
        if (cmd_ready) begin
          state_d = retry_ok_s ? ST_BACKOFF : ST_IDLE;
        end else begin
          state_d = ST_ABORT;
        end
      end
      ST_BACKOFF:  state_d = tmr_expired_s ? ST_FETCH : ST_BACKOFF;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    txn_d      = txn_q;
    cmd_d      = cmd_q;
    done_d     = done_q;
    error_d    = error_q;
    tmr_load_s = 1'b0;
`ifdef ADAU_SEQ_RETRY_EN
    tries_d     = tries_q;
    retry_cnt_d = retry_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = {ADDR_W{1'b0}};
          txn_d   = {ADDR_W{1'b0}};
          done_d  = 1'b0;
          error_d = 1'b0;
`ifdef ADAU_SEQ_RETRY_EN
          tries_d     = 8'd0;
          retry_cnt_d = 8'd0;
`endif
        end else begin
          addr_d = addr_q;
        end
      end
      ST_DECODE: begin
        case (op_s)
          OPC_BYTE:  cmd_d = '{stop: 1'b0, byte_val: rom_data[7:0]};
          OPC_STOP:  cmd_d = '{stop: 1'b1, byte_val: 8'h00};
          OPC_DELAY: tmr_load_s = 1'b1;
          OPC_NOP:   addr_d = addr_q + ADDR_W'(1);
          OPC_END:   done_d = 1'b1;
          default:   error_d = 1'b1;
        endcase
      end
      ST_SEND: begin
        // A completed STOP closes the transaction: it becomes the new rewind point.
        if (cmd_ready && cmd_q.stop) begin
          addr_d = addr_q + ADDR_W'(1);
          txn_d  = addr_q + ADDR_W'(1);
`ifdef ADAU_SEQ_RETRY_EN
          tries_d = 8'd0;
`endif
        end else begin
          addr_d = addr_q;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_valid && rsp_nack) begin
          cmd_d = '{stop: 1'b1, byte_val: 8'h00};
        end else if (rsp_valid) begin
          addr_d = addr_q + ADDR_W'(1);
        end else begin
          addr_d = addr_q;
        end
      end
      ST_DELAY: begin
        if (tmr_expired_s) begin
          addr_d = addr_q + ADDR_W'(1);
        end else begin
          addr_d = addr_q;
        end
      end
      ST_ABORT: begin
        if (cmd_ready && retry_ok_s) begin
          tmr_load_s = 1'b1;
`ifdef ADAU_SEQ_RETRY_EN
          tries_d     = tries_q + 8'd1;
          retry_cnt_d = (retry_cnt_q == 8'hFF) ? 8'hFF : retry_cnt_q + 8'd1;
`endif
        end else if (cmd_ready) begin
          error_d = 1'b1;
        end else begin
          error_d = error_q;
        end
      end
      ST_BACKOFF: begin
        if (tmr_expired_s) begin
          addr_d = txn_q;
        end else begin
          addr_d = addr_q;
        end
      end
      default: addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= {ADDR_W{1'b0}};
      txn_q   <= {ADDR_W{1'b0}};
      cmd_q   <= '{stop: 1'b0, byte_val: 8'h00};
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef ADAU_SEQ_RETRY_EN
      tries_q     <= 8'd0;
      retry_cnt_q <= 8'd0;
`endif
    end else begin
      addr_q  <= addr_d;
      txn_q   <= txn_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef ADAU_SEQ_RETRY_EN
      tries_q     <= tries_d;
      retry_cnt_q <= retry_cnt_d;
`endif
    end
  end

  always_comb begin
    rom_addr  = addr_q;
    cmd_valid = (state_q == ST_SEND) || (state_q == ST_ABORT);
    cmd_stop  = cmd_q.stop;
    cmd_byte  = cmd_q.byte_val;
    busy      = (state_q != ST_IDLE);
    done      = done_q;
    error     = error_q;
`ifdef ADAU_SEQ_RETRY_EN
    retry_cnt = retry_cnt_q;
`else
    retry_cnt = 8'd0;
`endif
  end

endmodule
